mul_iter_unit: RTL and testbench

- Iterative 64x64 integer multiplier for the RV64M MUL/MULH/MULHSU/MULHU group.
- Sits directly downstream of the 64-bit 4:1 operand-select multiplexer: operand A arrives from that mux output, operand B from the register-read path.
- Holds the EX stage through a valid/ready handshake until the selected 64-bit result half is registered.

---
 rtl/mul_pkg.sv | 26 ++
 rtl/mul_iter_unit_if.sv | 27 ++
 rtl/mul_step.sv | 30 +++
 rtl/mul_iter_unit.sv | 93 +++++++++
 tb/tb_mul_iter_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared encodings for the iterative RV64M multiplier: op codes, FSM states,
// operand width and the two's-complement magnitude helper used at acceptance.
package mul_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

  // -2^63 maps to 2^63, which is still representable as an unsigned magnitude.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
    return s ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_iter_unit_if.sv
// Operand/result handshake bundle between the EX stage and the multiplier.
// Slave is the multiplier side, master the issuing side.
interface mul_iter_unit_if;
  import mul_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/mul_step.sv
// One shift-add iteration of a right-shifting 128-bit accumulator:
// adds multiplicand*bits into the upper half, then shifts right by BPC.
module mul_step
  import mul_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   mcand,
  input  logic [BPC-1:0]    mbits,
  output logic [2*XLEN-1:0] acc_next
);

  localparam int SW = 2*XLEN + BPC + 1;

  logic [XLEN+BPC-1:0] pp;
  logic [SW-1:0]       sum;
  logic                unused_sum;

  // The partial product never exceeds 2^128 once shifted, so the top bit and
  // the shifted-out low bits are always zero.
  always_comb begin
    pp       = {{BPC{1'b0}}, mcand} * {{XLEN{1'b0}}, mbits};
    sum      = {{(BPC+1){1'b0}}, acc} + {1'b0, pp, {XLEN{1'b0}}};
    acc_next = sum[BPC +: 2*XLEN];
  end

  assign unused_sum = ^{sum[SW-1], sum[BPC-1:0]};

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative 64x64 multiplier for MUL/MULH/MULHSU/MULHU; result after N+2 cycles.
// Single operation in flight; DONE holds result until out_ready, flush aborts.
module mul_iter_unit
  import mul_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  mul_iter_unit_if.slave io
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N);

  mul_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [127:0]    acc_q;
  logic [127:0]    step_acc;
  logic [127:0]    fixed;
  logic [XLEN-1:0] ma_q, mb_q;
  logic            neg_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] result_q;
  logic            sign_a, sign_b, accept, last_iter;

  assign sign_a    = io.a[XLEN-1] & ((io.op == MUL_OP_MULH) | (io.op == MUL_OP_MULHSU));
  assign sign_b    = io.b[XLEN-1] & (io.op == MUL_OP_MULH);
  assign accept    = io.in_valid & io.in_ready;
  assign last_iter = (cnt_q == CW'(N-1));
  assign fixed     = neg_q ? (~acc_q + 128'd1) : acc_q;

  assign io.in_ready  = (state_q == IDLE) & ~io.flush;
  assign io.out_valid = (state_q == DONE);
  assign io.busy      = (state_q != IDLE);
  assign io.result    = result_q;

  mul_step #(.BPC(BITS_PER_CYCLE)) u_step (
    .acc      (acc_q),
    .mcand    (ma_q),
    .mbits    (mb_q[BITS_PER_CYCLE-1:0]),
    .acc_next (step_acc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (io.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = CALC;
        CALC:    if (last_iter) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    if (io.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      neg_q    <= 1'b0;
      op_q     <= MUL_OP_MUL;
      result_q <= '0;
    end else begin
      if (state_q == IDLE && accept) begin
        ma_q  <= mag(io.a, sign_a);
        mb_q  <= mag(io.b, sign_b);
        neg_q <= sign_a ^ sign_b;
        op_q  <= io.op;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == CALC && !io.flush) begin
        acc_q <= step_acc;
        mb_q  <= mb_q >> BITS_PER_CYCLE;
        cnt_q <= last_iter ? '0 : cnt_q + CW'(1);
      end
      if (state_q == FIX && !io.flush) begin
        result_q <= (op_q == MUL_OP_MUL) ? fixed[63:0] : fixed[127:64];
      end
    end
  end

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed bench for mul_iter_unit: corner products, latency, backpressure,
// flush, asynchronous reset and back-to-back issue against a reference product.
module tb_mul_iter_unit;
  import mul_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mul_iter_unit_if mi();
  mul_iter_unit_if mi4();

  mul_iter_unit #(.BITS_PER_CYCLE(1)) dut (.clock(clock), .reset_n(reset_n), .io(mi));
  mul_iter_unit #(.BITS_PER_CYCLE(4)) dut4 (.clock(clock), .reset_n(reset_n), .io(mi4));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] xa, xb, p;
    xa = {{64{a[63] & ((op == 2'd1) | (op == 2'd2))}}, a};
    xb = {{64{b[63] & (op == 2'd1)}}, b};
    p  = xa * xb;
    return (op == 2'd0) ? p[63:0] : p[127:64];
  endfunction

  // Cycle 0 is the cycle in_valid is presented; DONE must be visible in cycle N+2.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp);
    int cyc;
    mi.op = op; mi.a = a; mi.b = b; mi.in_valid = 1'b1; mi.out_ready = 1'b1;
    chk({tag, "_in_ready"}, 64'(mi.in_ready), 64'd1);
    tick();
    mi.in_valid = 1'b0;
    cyc = 1;
    while (!mi.out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd66);
    chk({tag, "_result"}, mi.result, exp);
    tick();
    chk({tag, "_out_valid_drop"}, 64'(mi.out_valid), 64'd0);
    chk({tag, "_in_ready_after"}, 64'(mi.in_ready), 64'd1);
  endtask

  task automatic run_op4(input string tag, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
    int cyc;
    mi4.op = op; mi4.a = a; mi4.b = b; mi4.in_valid = 1'b1; mi4.out_ready = 1'b1;
    tick();
    mi4.in_valid = 1'b0;
    cyc = 1;
    while (!mi4.out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd18);
    chk({tag, "_result"}, mi4.result, exp);
    tick();
    chk({tag, "_out_valid_drop"}, 64'(mi4.out_valid), 64'd0);
  endtask

  initial begin
    int cyc;
    logic seen;
    logic [1:0]  bop [4];
    logic [63:0] ba [4];
    logic [63:0] bb [4];

    mi.in_valid = 0; mi.op = 0; mi.a = 0; mi.b = 0; mi.flush = 0; mi.out_ready = 0;
    mi4.in_valid = 0; mi4.op = 0; mi4.a = 0; mi4.b = 0; mi4.flush = 0; mi4.out_ready = 0;

    #12;
    chk("reset_in_ready", 64'(mi.in_ready), 64'd1);
    chk("reset_out_valid", 64'(mi.out_valid), 64'd0);
    chk("reset_busy", 64'(mi.busy), 64'd0);
    chk("reset_result", mi.result, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    run_op("mul_3x5", 2'd0, 64'd3, 64'd5, 64'h000000000000000F);
    run_op("mulh_min", 2'd1, 64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000);
    run_op("mulh_m1", 2'd1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000);
    run_op("mulhu_max", 2'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE);
    run_op("mulhsu", 2'd2, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF);
    run_op("mul_lo_mix", 2'd0, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 64'h8000000000000000);
    run_op("mul_zero", 2'd0, 64'd0, 64'h123456789ABCDEF0, 64'd0);

    run_op4("bpc4_mul_3x5", 2'd0, 64'd3, 64'd5, 64'h000000000000000F);
    run_op4("bpc4_mulh_min", 2'd1, 64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000);
    run_op4("bpc4_mulhu_max", 2'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE);

    // Backpressure: result parked in DONE for 10 cycles while in_valid toggles.
    mi.op = 2'd0; mi.a = 64'h1234; mi.b = 64'h10; mi.in_valid = 1'b1; mi.out_ready = 1'b0;
    tick();
    mi.in_valid = 1'b0;
    cyc = 1;
    while (!mi.out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("bp_latency", 64'(cyc), 64'd66);
    for (int i = 0; i < 10; i++) begin
      mi.in_valid = i[0];
      mi.a = 64'(i + 100);
      tick();
      chk("bp_out_valid_hold", 64'(mi.out_valid), 64'd1);
      chk("bp_result_hold", mi.result, 64'h12340);
      chk("bp_in_ready_low", 64'(mi.in_ready), 64'd0);
    end
    mi.in_valid = 1'b0;
    mi.out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", 64'(mi.out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(mi.in_ready), 64'd1);
    chk("bp_release_busy", 64'(mi.busy), 64'd0);

    // Flush on CALC cycle 20.
    mi.op = 2'd0; mi.a = 64'd9; mi.b = 64'd9; mi.in_valid = 1'b1;
    tick();
    mi.in_valid = 1'b0;
    repeat (19) tick();
    chk("flush_busy_before", 64'(mi.busy), 64'd1);
    mi.flush = 1'b1;
    chk("flush_in_ready_low", 64'(mi.in_ready), 64'd0);
    tick();
    chk("flush_busy_after", 64'(mi.busy), 64'd0);
    chk("flush_out_valid", 64'(mi.out_valid), 64'd0);
    mi.in_valid = 1'b1;
    chk("flush_idle_in_ready", 64'(mi.in_ready), 64'd0);
    tick();
    chk("flush_no_accept", 64'(mi.busy), 64'd0);
    mi.flush = 1'b0;
    mi.in_valid = 1'b0;
    seen = 1'b0;
    repeat (70) begin
      tick();
      if (mi.out_valid) seen = 1'b1;
    end
    chk("flush_out_valid_never", 64'(seen), 64'd0);
    run_op("flush_then_mul", 2'd0, 64'd7, 64'd6, 64'h000000000000002A);

    // Asynchronous reset mid-CALC, checked between clock edges.
    mi.op = 2'd3; mi.a = 64'hFFFFFFFFFFFFFFFF; mi.b = 64'hFFFFFFFFFFFFFFFF; mi.in_valid = 1'b1;
    tick();
    mi.in_valid = 1'b0;
    repeat (10) tick();
    chk("arst_busy_before", 64'(mi.busy), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(mi.out_valid), 64'd0);
    chk("arst_busy", 64'(mi.busy), 64'd0);
    chk("arst_in_ready", 64'(mi.in_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    run_op("arst_then_mulhu", 2'd3, 64'h0000000100000000, 64'h0000000100000000, 64'h0000000000000001);

    // Back-to-back with in_valid held high throughout.
    for (int i = 0; i < 4; i++) begin
      bop[i] = 2'(i);
      ba[i]  = {$urandom, $urandom};
      bb[i]  = {$urandom, $urandom};
    end
    ba[1][63] = 1'b1;
    mi.out_ready = 1'b1;
    mi.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mi.op = bop[i]; mi.a = ba[i]; mi.b = bb[i];
      chk("b2b_in_ready_idle", 64'(mi.in_ready), 64'd1);
      tick();
      chk("b2b_busy_accept", 64'(mi.busy), 64'd1);
      seen = 1'b0;
      cyc = 1;
      while (!mi.out_valid && cyc < 200) begin
        if (mi.in_ready) seen = 1'b1;
        tick();
        cyc++;
      end
      chk("b2b_ready_while_busy", 64'(seen), 64'd0);
      chk("b2b_latency", 64'(cyc), 64'd66);
      chk("b2b_result", mi.result, ref_mul(bop[i], ba[i], bb[i]));
      tick();
      chk("b2b_return_idle", 64'(mi.busy), 64'd0);
    end
    mi.in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
